// File: rtl/activation_engine.sv
// Streaming hard-activation unit: read word, apply activation, write result, 3 cycles/element.
// Optional macro ACT_LEAKY_RELU_EN makes opcode 0x4D (leaky ReLU) legal and builds its datapath.
module activation_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [6:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  localparam logic [6:0] OP_SIGMOID = 7'h4A;
  localparam logic [6:0] OP_TANH    = 7'h4B;
  localparam logic [6:0] OP_RELU    = 7'h4C;
  localparam logic [6:0] OP_LEAKY   = 7'h4D;

  localparam logic signed [DATA_WIDTH-1:0] ONE_C  = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] TWO_C  = ONE_C <<< 1;
  localparam logic signed [DATA_WIDTH-1:0] HALF_C = ONE_C >>> 1;

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    ok = (op == OP_SIGMOID) || (op == OP_TANH) || (op == OP_RELU);
`ifdef ACT_LEAKY_RELU_EN
    ok = ok || (op == OP_LEAKY);
`endif
    return ok;
  endfunction

  // Every branch stays within [-ONE, ONE] or is the input itself, so no overflow path exists.
  function automatic logic signed [DATA_WIDTH-1:0] act_fn(input logic [6:0] op,
                                                          input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_SIGMOID: begin
        if (x >= TWO_C)       r = ONE_C;
        else if (x <= -TWO_C) r = '0;
        else                  r = HALF_C + (x >>> 2);
      end
      OP_TANH: begin
        if (x > ONE_C)       r = ONE_C;
        else if (x < -ONE_C) r = -ONE_C;
        else                 r = x;
      end
      OP_RELU: r = (x < 0) ? '0 : x;
`ifdef ACT_LEAKY_RELU_EN
      OP_LEAKY: r = (x < 0) ? (x >>> 3) : x;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t                       state_q, state_d;
  logic [6:0]                   op_q, op_d;
  logic [ADDR_WIDTH-1:0]        src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d, idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;
  logic                         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    res_d       = res_q;
    err_d       = err_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    done        = 1'b0;
    error       = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode;
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = length;
          idx_d = '0;
          err_d = !op_legal(opcode);
          state_d = (op_legal(opcode) && (length != '0)) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_q + ADDR_WIDTH'(idx_q);
        state_d     = S_CALC;
      end
      S_CALC: begin
        res_d   = act_fn(op_q, mem_rd_data);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = dst_q + ADDR_WIDTH'(idx_q);
        mem_wr_data = res_q;
        idx_d       = idx_q + LEN_WIDTH'(1);
        state_d     = (idx_q == len_q - LEN_WIDTH'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        error   = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_activation_engine.sv
// Directed bench for activation_engine: scratchpad model, cycle-stamped monitor, hand-computed vectors.
module tb_activation_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic [11:0] src_addr = '0, dst_addr = '0;
  logic [7:0]  length = '0;
  logic        mem_rd_en, mem_wr_en, busy, done, error;
  logic [11:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] mem_wr_data;

  activation_engine dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:4095];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], rd_addr_q[$];
  int          n_done = 0, done_cyc = 0, busy_cnt = 0, viol = 0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_addr_q.push_back(int'(mem_wr_addr));
      wr_data_q.push_back(int'(mem_wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (mem_rd_en) rd_addr_q.push_back(int'(mem_rd_addr));
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_err = error;
    end
    if (busy) busy_cnt++;
    if ((mem_rd_en && mem_wr_en) || (done && mem_wr_en) || (error && !done)) viol++;
  end

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); rd_addr_q.delete();
    n_done = 0; done_cyc = 0; busy_cnt = 0; viol = 0; done_err = 1'b0;
  endtask

  logic [31:0] exp_d [0:7];
  int          t0;

  task automatic issue(input logic [6:0] op, input logic [11:0] src, input logic [11:0] dst,
                       input logic [7:0] len);
    @(negedge clk);
    clear_mon();
    start = 1'b1; opcode = op; src_addr = src; dst_addr = dst; length = len;
    @(posedge clk); #1;
    t0 = cyc;
    // Scramble the command inputs to prove the engine latched them.
    start = 1'b0; opcode = 7'h10; src_addr = 12'h555; dst_addr = 12'hAAA; length = 8'hFF;
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [11:0] src,
                     input logic [11:0] dst, input logic [7:0] len, input int inject_at,
                     input logic exp_err, input logic exp_traffic);
    int n_exp, done_rel, n;
    n_exp    = exp_traffic ? int'(len) : 0;
    done_rel = exp_traffic ? 3 * int'(len) + 1 : 1;
    issue(op, src, dst, len);
    for (int i = 0; i < 200 && n_done == 0; i++) begin
      @(negedge clk); #1;
      if (i == inject_at) begin
        start = 1'b1; opcode = 7'h4C; src_addr = 12'h000; dst_addr = 12'h000; length = 8'd9;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (n_done == 0) chk({nm, ".timeout"}, 32'(n_done), 32'd1);
    repeat (4) @(negedge clk);
    chk({nm, ".done_cyc"}, 32'(done_cyc - t0 + 1), 32'(done_rel));
    chk({nm, ".error"}, {31'd0, done_err}, {31'd0, exp_err});
    chk({nm, ".n_done"}, 32'(n_done), 32'd1);
    chk({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(done_rel));
    chk({nm, ".overlap"}, 32'(viol), 32'd0);
    chk({nm, ".n_writes"}, 32'(wr_addr_q.size()), 32'(n_exp));
    chk({nm, ".n_reads"}, 32'(rd_addr_q.size()), 32'(n_exp));
    n = (wr_addr_q.size() < n_exp) ? wr_addr_q.size() : n_exp;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.wdata%0d", nm, k), 32'(wr_data_q[k]), exp_d[k]);
      chk($sformatf("%s.waddr%0d", nm, k), 32'(wr_addr_q[k]), {20'd0, dst + 12'(k)});
      chk($sformatf("%s.wcyc%0d", nm, k), 32'(wr_cyc_q[k] - t0 + 1), 32'(3 + 3 * k));
    end
    n = (rd_addr_q.size() < n_exp) ? rd_addr_q.size() : n_exp;
    for (int k = 0; k < n; k++)
      chk($sformatf("%s.raddr%0d", nm, k), 32'(rd_addr_q[k]), {20'd0, src + 12'(k)});
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".ctl"}, {27'd0, mem_rd_en, mem_wr_en, busy, done, error}, 32'd0);
    chk({nm, ".addrs"}, {8'd0, mem_rd_addr, mem_wr_addr}, 32'd0);
    chk({nm, ".wdata"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h100] = 32'h0001_0000; mem[12'h101] = 32'h0003_0000;
    mem[12'h102] = 32'hFFFE_0000; mem[12'h103] = 32'h0000_0000;
    mem[12'h200] = 32'h0000_8000; mem[12'h201] = 32'h0002_0000; mem[12'h202] = 32'hFFFE_0000;
    mem[12'h300] = 32'h0001_2345; mem[12'h301] = 32'hFFFF_0000;
    mem[12'h500] = 32'hFFF8_0000;
    mem[12'hFFE] = 32'h0000_0011; mem[12'hFFF] = 32'hFFFF_FFFF; mem[12'h000] = 32'h7FFF_FFFF;
    mem[12'h600] = 32'h0001_0000; mem[12'h601] = 32'h0001_0000; mem[12'h602] = 32'h0001_0000;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    exp_d[0] = 32'h0000_C000; exp_d[1] = 32'h0001_0000;
    exp_d[2] = 32'h0000_0000; exp_d[3] = 32'h0000_8000;
    run("sigmoid", 7'h4A, 12'h100, 12'h180, 8'd4, -1, 1'b0, 1'b1);

    exp_d[0] = 32'h0000_8000; exp_d[1] = 32'h0001_0000; exp_d[2] = 32'hFFFF_0000;
    run("tanh", 7'h4B, 12'h200, 12'h280, 8'd3, -1, 1'b0, 1'b1);

    exp_d[0] = 32'h0001_2345; exp_d[1] = 32'h0000_0000;
    run("relu_midstart", 7'h4C, 12'h300, 12'h380, 8'd2, 2, 1'b0, 1'b1);

`ifdef ACT_LEAKY_RELU_EN
    exp_d[0] = 32'hFFFF_0000;
    run("leaky", 7'h4D, 12'h500, 12'h580, 8'd1, -1, 1'b0, 1'b1);
`else
    run("leaky_off", 7'h4D, 12'h500, 12'h580, 8'd1, -1, 1'b1, 1'b0);
`endif

    run("len0", 7'h4C, 12'h300, 12'h380, 8'd0, -1, 1'b0, 1'b0);
    run("badop", 7'h10, 12'h300, 12'h380, 8'd2, -1, 1'b1, 1'b0);

    exp_d[0] = 32'h0000_0011; exp_d[1] = 32'h0000_0000; exp_d[2] = 32'h7FFF_FFFF;
    run("wrap", 7'h4C, 12'hFFE, 12'hFFF, 8'd3, -1, 1'b0, 1'b1);

    // Abort during element 1's CALC cycle (5th cycle after acceptance).
    issue(7'h4A, 12'h600, 12'h680, 8'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort.n_done", 32'(n_done), 32'd0);
    chk("abort.traffic", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'd0);

    exp_d[0] = 32'h0000_C000;
    run("after_abort", 7'h4A, 12'h600, 12'h680, 8'd1, -1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_engine.md
# activation_engine

Parametrised streaming activation unit for the RV32 accelerator datapath. On a `start` command it reads `length` signed fixed-point words from scratchpad memory at `src_addr`, applies the activation selected by `opcode` to each word, and writes the results to `dst_addr`, then pulses `done`. It sits beside the matrix unit, sharing the scratchpad through a single-read, single-write port pair.

## Interface
- `ADDR_WIDTH`, 12: scratchpad word-address width.
- `DATA_WIDTH`, 32: word width, signed two's complement.
- `FRAC_BITS`, 16: fractional bits of the Q format; ONE = 1 << FRAC_BITS.
- `LEN_WIDTH`, 8: width of the element-count field.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `opcode` input 7: 0x4A sigmoid, 0x4B tanh, 0x4C ReLU, 0x4D leaky ReLU (see Configuration).
- `src_addr` input ADDR_WIDTH: first source word address.
- `dst_addr` input ADDR_WIDTH: first destination word address.
- `length` input LEN_WIDTH: number of elements.
- `mem_rd_en` output 1: read request.
- `mem_rd_addr` output ADDR_WIDTH: read address.
- `mem_rd_data` input DATA_WIDTH: read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en` output 1: write strobe.
- `mem_wr_addr` output ADDR_WIDTH: write address.
- `mem_wr_data` output DATA_WIDTH: write data.
- `busy` output 1: high while a command is in progress.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: one-cycle pulse with `done` when the opcode is illegal.

## Operation
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- In IDLE with `start`=1, the block latches opcode, addresses and length, and clears the element counter.
  - If the opcode is legal and length > 0, it goes to READ.
  - Otherwise it goes to DONE. Length 0 gives `done` only. An illegal opcode gives `done` and `error`. Neither case produces any memory traffic.
- READ asserts `mem_rd_en` with `mem_rd_addr` = src + idx, then goes to CALC.
- CALC captures `mem_rd_data`, computes the result into a result register, then goes to WRITE.
- WRITE asserts `mem_wr_en` with `mem_wr_addr` = dst + idx and `mem_wr_data` = result, then increments idx. It goes to DONE if idx was length-1, otherwise back to READ.
- DONE pulses `done` (and `error` if applicable), then returns to IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- `start` outside IDLE is ignored. `opcode` and the addresses may change freely after acceptance.
- Arithmetic, with x signed and shifts arithmetic:
  - Sigmoid (hard): x >= 2·ONE gives ONE; x <= -2·ONE gives 0; otherwise ONE/2 + (x >>> 2).
  - Tanh (hard): clamp x to [-ONE, ONE].
  - ReLU: x < 0 gives 0; otherwise x.
  - Leaky ReLU: x < 0 gives x >>> 3; otherwise x.
- No intermediate result exceeds DATA_WIDTH+1 bits, and results never overflow.

## Timing
- Reset values: all outputs 0, FSM in IDLE, internal registers 0.
- Reset mid-command aborts immediately. No further reads or writes occur, and `done` is not pulsed.
- With `start` accepted at edge T:
  - READ occupies cycle T+1.
  - The first write is in cycle T+3.
  - Element k (0-based) is written in cycle T+3+3k.
  - `done` is high in cycle T+3N+1.
  - `busy` is high from T+1 through the DONE cycle inclusive.
- Zero-length or illegal command: `done` in cycle T+1, and `busy` is high in that cycle only.
- Throughput is 3 cycles per element. At most one memory access occurs per cycle, and reads and writes never overlap.
- `done` is never asserted in the same cycle as `mem_wr_en`.

## Configuration
- `ACT_LEAKY_RELU_EN` defined: opcode 0x4D is legal and computes leaky ReLU as specified.
- Not defined: 0x4D is illegal. It gets the illegal-opcode handling (`done` and `error` in T+1, no memory traffic), and the leaky datapath is not synthesised.

## Test plan
- Sigmoid, length 4, src words 0x00010000, 0x00030000, 0xFFFE0000, 0x00000000 -> writes 0x0000C000, 0x00010000, 0x00000000, 0x00008000 at dst..dst+3; `done` at T+13.
- Tanh, length 3, inputs 0x00008000, 0x00020000, 0xFFFE0000 -> 0x00008000, 0x00010000, 0xFFFF0000; ReLU on 0xFFFF0000 and 0x00012345 -> 0x00000000 and 0x00012345.
- Leaky ReLU on 0xFFF80000 -> 0xFFFF0000 with `ACT_LEAKY_RELU_EN`; without the macro -> `done` and `error` at T+1, `mem_rd_en` never asserted.
- Length 0, and opcode 0x10 -> `done` at T+1 with `error` 0 and 1 respectively, no memory strobes; a `start` pulsed mid-command is ignored.
- src = 0xFFE, dst = 0xFFF, length 3 -> reads 0xFFE, 0xFFF, 0x000 and writes 0xFFF, 0x000, 0x001.
- Assert `rst` during the second element's CALC -> all outputs 0 next edge, no `done`; a fresh command afterwards completes normally.
